carry_lookahead_adder_reg: RTL and testbench
============================================

// Module: carry_lookahead_adder_reg
// PURPOSE
// - Parameterised two-level carry-lookahead adder with a registered output stage.
// - Computes sum = a + b + carry_in, with carry-out, over WIDTH bits.
// - Used as the datapath adder in arithmetic blocks. Must build at WIDTH=16 and WIDTH=32.
// - Carries are resolved by lookahead logic, not by ripple.
// PARAMETERS
// - WIDTH  16  operand/sum width; multiple of 4, >= 4 (16 and 32 mandatory)
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      reset; asynchronous, active-low
// - in_valid   in   1      a/b/carry_in are sampled this cycle
// - a          in   WIDTH  operand A, unsigned
// - b          in   WIDTH  operand B, unsigned
// - carry_in   in   1      carry into bit 0
// - out_valid  out  1      sum/carry_out hold a new result
// - sum        out  WIDTH  registered (a + b + carry_in) mod 2^WIDTH
// - carry_out  out  1      registered carry out of bit WIDTH-1
// - overflow   out  1      present only with CLA_OVERFLOW_EN (see CONFIGURATION)
// BEHAVIOUR
// - Interface: one clock (clk); reset rst_n is asynchronous and active-low.
// - Bit level:
//   - g[i] = a[i] & b[i]
//   - p[i] = a[i] ^ b[i]
// - Carries are computed in 4-bit groups:
//   - Per-group GG/PG are formed from g/p.
//   - A second-level lookahead across groups derives each group carry-in from
//     carry_in plus the GG/PG of the lower groups.
//   - Inside each group, internal carries use expanded lookahead equations.
// - sum[i] = p[i] ^ c[i]; carry_out = c[WIDTH].
// - Result is bit-exact with {carry_out,sum} = a + b + carry_in, computed at WIDTH+1 bits.
// - Latency: 1 cycle.
//   - On a rising clk with in_valid=1, sum/carry_out load the combinational result.
//   - out_valid goes to 1 on that same edge.
//   - On a rising clk with in_valid=0, sum/carry_out hold their value and out_valid
//     goes to 0.
// - No backpressure; one new operation may be accepted every cycle.
// - Reset: when rst_n=0, sum=0, carry_out=0, out_valid=0 (and overflow=0)
//   immediately, with no clock needed.
//   - Reset asserted mid-operation discards the in-flight result.
//   - After rst_n rises, the first valid result appears 1 cycle after the first
//     in_valid edge.
// - Wrap-around: all-ones + 1, or a sum exceeding 2^WIDTH-1, wraps mod 2^WIDTH
//   with carry_out=1.
// - carry_in=1 with a=b=all-ones gives sum = all-ones and carry_out=1.
// - No state machine; the only state is the output register.
// CONFIGURATION
// - CLA_OVERFLOW_EN defined:
//   - Adds output port overflow (1 bit), registered alongside sum.
//   - overflow = c[WIDTH] ^ c[WIDTH-1] (two's-complement signed overflow).
//   - Reset value is 0.
// - CLA_OVERFLOW_EN undefined: the overflow port and its logic do not exist.
// TESTING
// - Test 1 (WIDTH=16): a=1A2B, b=3C4D, cin=0, in_valid=1
//   -> next edge: sum=5678, carry_out=0, out_valid=1.
// - Test 2 (WIDTH=16): a=FFFF, b=0001, cin=1
//   -> sum=0001, carry_out=1.
// - Test 3 (WIDTH=32): a=FFFFFFFF, b=00000001, cin=0 -> sum=00000000, carry_out=1.
//   Then a=1A2B3C4D, b=11111111, cin=1 -> sum=2B3C4D5F, carry_out=0.
// - Test 4: load a result, then drop rst_n between clock edges
//   -> sum=0, carry_out=0, out_valid=0 at once.
//   - Release rst_n, hold in_valid=0 -> outputs remain 0.
// - Test 5: in_valid=0 for 3 cycles after a valid op
//   -> sum/carry_out unchanged, out_valid=0.
//   - Also run 1000 random vectors per width against the a+b+cin reference model.
// - Test 6 (CLA_OVERFLOW_EN, WIDTH=16): a=7FFF, b=0001, cin=0
//   -> sum=8000, overflow=1, carry_out=0.
//   - a=8000, b=8000 -> sum=0000, overflow=1, carry_out=1.

Source files
------------

// File: rtl/carry_lookahead_adder_reg.sv
// Two-level carry-lookahead adder with registered sum/carry_out.
// Define CLA_OVERFLOW_EN to add a registered signed-overflow output.
module carry_lookahead_adder_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef CLA_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    pg;
  logic [NG:0]      gc;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;
  logic             acc;
  logic             term;

  always_comb begin
    g     = a & b;
    p     = a ^ b;
    gg    = '0;
    pg    = '0;
    gc    = '0;
    c     = '0;
    acc   = 1'b0;
    term  = 1'b0;

    for (int j = 0; j < NG; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1]
               & g[4*j]);
      pg[j] = p[4*j+3] & p[4*j+2]
            & p[4*j+1] & p[4*j];
    end

    // Each group carry is a flat sum of products over lower groups.
    gc[0] = carry_in;
    for (int j = 1; j <= NG; j++) begin
      term = carry_in;
      for (int m = 0; m < j; m++)
        term = term & pg[m];
      acc = term;
      for (int k = 0; k < j; k++) begin
        term = gg[k];
        for (int m = k + 1; m < j; m++)
          term = term & pg[m];
        acc = acc | term;
      end
      gc[j] = acc;
    end

    for (int j = 0; j < NG; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j]
               | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1]
               | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2]
               | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j]
                  & gc[j]);
    end
    c[WIDTH] = gc[NG];

    sum_d = p ^ c[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum       <= sum_d;
        carry_out <= c[WIDTH];
      end
    end
  end

`ifdef CLA_OVERFLOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (in_valid)
      overflow <= c[WIDTH] ^ c[WIDTH-1];
  end
`endif

endmodule

// File: tb/tb_carry_lookahead_adder_reg.sv
// Randomised + directed bench for carry_lookahead_adder_reg.
// Checks WIDTH=16 and WIDTH=32 instances against a+b+cin.
module tb_carry_lookahead_adder_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        v16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        ci16 = 1'b0;
  logic        ov16;
  logic [15:0] s16;
  logic        co16;

  logic        v32 = 1'b0;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic        ci32 = 1'b0;
  logic        ov32;
  logic [31:0] s32;
  logic        co32;

`ifdef CLA_OVERFLOW_EN
  logic        of16;
  logic        of32;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  carry_lookahead_adder_reg #(.WIDTH(16)) u16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v16),
    .a         (a16),
    .b         (b16),
    .carry_in  (ci16),
    .out_valid (ov16),
    .sum       (s16),
    .carry_out (co16)
`ifdef CLA_OVERFLOW_EN
    ,
    .overflow  (of16)
`endif
  );

  carry_lookahead_adder_reg #(.WIDTH(32)) u32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v32),
    .a         (a32),
    .b         (b32),
    .carry_in  (ci32),
    .out_valid (ov32),
    .sum       (s32),
    .carry_out (co32)
`ifdef CLA_OVERFLOW_EN
    ,
    .overflow  (of32)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({ov16, s16, co16} !== 17'h0) begin
      n_err++;
      $display("FAIL reset16: got v=%b s=%h c=%b want 0",
               ov16, s16, co16);
    end
    n_cmp++;
    if ({ov32, s32, co32} !== 33'h0) begin
      n_err++;
      $display("FAIL reset32: got v=%b s=%h c=%b want 0",
               ov32, s32, co32);
    end
    #10;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed16(input logic [15:0] x,
                                 input logic [15:0] y,
                                 input logic ci,
                                 input logic [15:0] es,
                                 input logic ec);
    v16 = 1'b1; a16 = x; b16 = y; ci16 = ci;
    tick();
    v16 = 1'b0;
    n_cmp++;
    if ({ov16, s16, co16} !== {1'b1, es, ec}) begin
      n_err++;
      $display("FAIL dir16 %h+%h+%b: got v=%b s=%h c=%b want v=1 s=%h c=%b",
               x, y, ci, ov16, s16, co16, es, ec);
    end
  endtask

  task automatic test_directed32(input logic [31:0] x,
                                 input logic [31:0] y,
                                 input logic ci,
                                 input logic [31:0] es,
                                 input logic ec);
    v32 = 1'b1; a32 = x; b32 = y; ci32 = ci;
    tick();
    v32 = 1'b0;
    n_cmp++;
    if ({ov32, s32, co32} !== {1'b1, es, ec}) begin
      n_err++;
      $display("FAIL dir32 %h+%h+%b: got v=%b s=%h c=%b want v=1 s=%h c=%b",
               x, y, ci, ov32, s32, co32, es, ec);
    end
  endtask

  task automatic test_async_reset();
    v16 = 1'b1; a16 = 16'h1234; b16 = 16'h4321; ci16 = 1'b1;
    v32 = 1'b1; a32 = 32'hdeadbeef; b32 = 32'h1; ci32 = 1'b0;
    tick();
    v16 = 1'b0;
    v32 = 1'b0;
    n_cmp++;
    if ({ov16, s16} !== {1'b1, 16'h5556}) begin
      n_err++;
      $display("FAIL preload16: got v=%b s=%h want v=1 s=5556",
               ov16, s16);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ov16, s16, co16} !== 17'h0) begin
      n_err++;
      $display("FAIL async16: got v=%b s=%h c=%b want 0",
               ov16, s16, co16);
    end
    n_cmp++;
    if ({ov32, s32, co32} !== 33'h0) begin
      n_err++;
      $display("FAIL async32: got v=%b s=%h c=%b want 0",
               ov32, s32, co32);
    end
    #2;
    rst_n = 1'b1;
    a16 = 16'hffff; b16 = 16'hffff;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({ov16, s16, co16} !== 17'h0) begin
        n_err++;
        $display("FAIL idle16 cyc%0d: got v=%b s=%h c=%b want 0",
                 i, ov16, s16, co16);
      end
    end
  endtask

  task automatic test_hold();
    v16 = 1'b1; a16 = 16'hf000; b16 = 16'h1001; ci16 = 1'b0;
    tick();
    v16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      ci16 = 1'($urandom);
      tick();
      n_cmp++;
      if ({ov16, s16, co16} !== {1'b0, 16'h0001, 1'b1}) begin
        n_err++;
        $display("FAIL hold16 cyc%0d: got v=%b s=%h c=%b want v=0 s=0001 c=1",
                 i, ov16, s16, co16);
      end
    end
  endtask

  task automatic test_random();
    logic [16:0] e16;
    logic [32:0] e32;
    logic        ev16;
    logic        ev32;
    logic        eo16;
    logic        eo32;
    logic [16:0] r16;
    logic [32:0] r32;
    e16 = {co16, s16};
    e32 = {co32, s32};
    ev16 = 1'b0;
    ev32 = 1'b0;
    eo16 = 1'b0;
    eo32 = 1'b0;
`ifdef CLA_OVERFLOW_EN
    eo16 = of16;
    eo32 = of32;
`endif
    for (int i = 0; i < 1000; i++) begin
      v16 = ($urandom_range(9) != 0);
      v32 = ($urandom_range(9) != 0);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      a32 = $urandom;
      b32 = $urandom;
      if (i % 50 == 0) begin
        a16 = 16'hffff;
        a32 = 32'hffffffff;
      end
      ci16 = 1'($urandom);
      ci32 = 1'($urandom);
      r16 = 17'(a16) + 17'(b16) + 17'(ci16);
      r32 = 33'(a32) + 33'(b32) + 33'(ci32);
      ev16 = v16;
      ev32 = v32;
      if (v16) begin
        e16 = r16;
        eo16 = (a16[15] == b16[15]) && (r16[15] != a16[15]);
      end
      if (v32) begin
        e32 = r32;
        eo32 = (a32[31] == b32[31]) && (r32[31] != a32[31]);
      end
      tick();
      n_cmp++;
      if ({ov16, co16, s16} !== {ev16, e16}) begin
        n_err++;
        $display("FAIL rand16 #%0d: got v=%b c=%b s=%h want v=%b c=%b s=%h",
                 i, ov16, co16, s16, ev16, e16[16], e16[15:0]);
      end
      n_cmp++;
      if ({ov32, co32, s32} !== {ev32, e32}) begin
        n_err++;
        $display("FAIL rand32 #%0d: got v=%b c=%b s=%h want v=%b c=%b s=%h",
                 i, ov32, co32, s32, ev32, e32[32], e32[31:0]);
      end
`ifdef CLA_OVERFLOW_EN
      n_cmp++;
      if ({of16, of32} !== {eo16, eo32}) begin
        n_err++;
        $display("FAIL randov #%0d: got %b%b want %b%b",
                 i, of16, of32, eo16, eo32);
      end
`endif
    end
    v16 = 1'b0;
    v32 = 1'b0;
  endtask

`ifdef CLA_OVERFLOW_EN
  task automatic test_overflow();
    v16 = 1'b1; a16 = 16'h7fff; b16 = 16'h0001; ci16 = 1'b0;
    tick();
    n_cmp++;
    if ({s16, of16, co16} !== {16'h8000, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL ovf_pos: got s=%h o=%b c=%b want s=8000 o=1 c=0",
               s16, of16, co16);
    end
    a16 = 16'h8000; b16 = 16'h8000;
    tick();
    v16 = 1'b0;
    n_cmp++;
    if ({s16, of16, co16} !== {16'h0000, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_neg: got s=%h o=%b c=%b want s=0000 o=1 c=1",
               s16, of16, co16);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed16(16'h1a2b, 16'h3c4d, 1'b0, 16'h5678, 1'b0);
    test_directed16(16'hffff, 16'h0001, 1'b1, 16'h0001, 1'b1);
    test_directed16(16'hffff, 16'hffff, 1'b1, 16'hffff, 1'b1);
    test_directed16(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    test_directed32(32'hffffffff, 32'h00000001, 1'b0,
                    32'h00000000, 1'b1);
    test_directed32(32'h1a2b3c4d, 32'h11111111, 1'b1,
                    32'h2b3c4d5f, 1'b0);
    test_directed32(32'hffffffff, 32'hffffffff, 1'b1,
                    32'hffffffff, 1'b1);
    test_async_reset();
    test_hold();
    test_random();
`ifdef CLA_OVERFLOW_EN
    test_overflow();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
